// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Initiator-side sequencer for the register file en/register_done handshake.
// Accepts one request (two reads plus an optional write), pulses rf_en for a
// single cycle, waits for register_done (bounded by TIMEOUT_CYCLES) and
// presents the captured operands on a valid/ready response port.
// Optional build macro: RF_BYPASS_EN selects write-first operand semantics
// (a request that writes rd returns its own wdata for rs/rt == rd).
// Without it, operands are the raw register file read data (read-first).
module regfile_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic              req_we,
    input  logic [4:0]        req_rd,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rf_en,
    output logic              rf_reg_write,
    output logic [4:0]        rf_read_reg1,
    output logic [4:0]        rf_read_reg2,
    output logic [4:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              rf_register_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last WAIT count at which a missing done turns into a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] cap_data1_s;
    logic [DATA_W-1:0] cap_data2_s;

`ifdef RF_BYPASS_EN
    // Remembers that the in-flight request really wrote (rd != 0); rf_reg_write
    // itself is already cleared by the time operands are captured.
    logic              wr_lat;
`endif

    // Ready only while idle and not being reset.
    assign req_ready = (state == IDLE) && !rst;

    // Operand selection at capture time (raw read data, or own write data when bypassing).
    always_comb begin
        cap_data1_s = rf_read_data1;
        cap_data2_s = rf_read_data2;
`ifdef RF_BYPASS_EN
        if (wr_lat && (rf_write_reg == rf_read_reg1)) begin
            cap_data1_s = rf_write_data;
        end else begin
            cap_data1_s = rf_read_data1;
        end
        if (wr_lat && (rf_write_reg == rf_read_reg2)) begin
            cap_data2_s = rf_write_data;
        end else begin
            cap_data2_s = rf_read_data2;
        end
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            rf_en         <= 1'b0;
            rf_reg_write  <= 1'b0;
            rf_read_reg1  <= 5'd0;
            rf_read_reg2  <= 5'd0;
            rf_write_reg  <= 5'd0;
            rf_write_data <= {DATA_W{1'b0}};
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_data1     <= {DATA_W{1'b0}};
            rsp_data2     <= {DATA_W{1'b0}};
            busy          <= 1'b0;
`ifdef RF_BYPASS_EN
            wr_lat        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rf_read_reg1  <= req_rs;
                        rf_read_reg2  <= req_rt;
                        rf_write_reg  <= req_rd;
                        rf_write_data <= req_wdata;
                        // Writes to r0 never reach the register file.
                        rf_reg_write  <= req_we && (req_rd != 5'd0);
`ifdef RF_BYPASS_EN
                        wr_lat        <= req_we && (req_rd != 5'd0);
`endif
                        rf_en         <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The register file samples en/write on this edge.
                    rf_en        <= 1'b0;
                    rf_reg_write <= 1'b0;
                    wait_cnt     <= 8'd0;
                    state        <= WAIT;
                end
                WAIT: begin
                    rf_en        <= 1'b0;
                    rf_reg_write <= 1'b0;
                    if (rf_register_done) begin
                        rsp_data1 <= cap_data1_s;
                        rsp_data2 <= cap_data2_s;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_data1 <= {DATA_W{1'b0}};
                        rsp_data2 <= {DATA_W{1'b0}};
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rf_en     <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: a behavioural register file
// with programmable done delay, a shadow register array as reference model,
// directed cases followed by randomized requests.
module tb_regfile_access_ctrl;

    localparam int TO = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic          req_we;
    logic [4:0]    req_rd;
    logic [DW-1:0] req_wdata;
    logic          rf_en;
    logic          rf_reg_write;
    logic [4:0]    rf_read_reg1;
    logic [4:0]    rf_read_reg2;
    logic [4:0]    rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data1;
    logic [DW-1:0] rf_read_data2;
    logic          rf_register_done;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          rsp_err;
    logic          busy;

    int n_checks;
    int n_errs;

    regfile_access_ctrl #(.TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_rs           (req_rs),
        .req_rt           (req_rt),
        .req_we           (req_we),
        .req_rd           (req_rd),
        .req_wdata        (req_wdata),
        .rf_en            (rf_en),
        .rf_reg_write     (rf_reg_write),
        .rf_read_reg1     (rf_read_reg1),
        .rf_read_reg2     (rf_read_reg2),
        .rf_write_reg     (rf_write_reg),
        .rf_write_data    (rf_write_data),
        .rf_read_data1    (rf_read_data1),
        .rf_read_data2    (rf_read_data2),
        .rf_register_done (rf_register_done),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data1        (rsp_data1),
        .rsp_data2        (rsp_data2),
        .rsp_err          (rsp_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural register file ----------------
    // No hardwired r0: if the controller ever wrote r0, a later read would show it.
    logic [DW-1:0] rf_mem [32];
    logic          mem_init;
    int            done_delay;
    int            done_cnt;
    logic          done_pend;

    // Register file: on en, read old values, perform write, then raise done after done_delay cycles.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_read_data1 <= '0;
            rf_read_data2 <= '0;
            done_pend     <= 1'b0;
            done_cnt      <= 0;
        end else if (rf_en) begin
            rf_read_data1 <= rf_mem[rf_read_reg1];
            rf_read_data2 <= rf_mem[rf_read_reg2];
            if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
            done_pend <= 1'b1;
            done_cnt  <= done_delay;
        end else if (done_pend) begin
            if (done_cnt == 0) done_pend <= 1'b0;
            else               done_cnt  <= done_cnt - 1;
        end
    end

    assign rf_register_done = done_pend && (done_cnt == 0);

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_regs [32];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [4:0] rs, input logic [4:0] rt, input logic we,
                          input logic [4:0] rd, input logic [DW-1:0] wd,
                          input int dly, input int stall);
        int            n;
        int            exp_lat;
        logic          wr;
        logic          to;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_val("req_ready_idle", req_ready, 1'b1);
        done_delay = dly;
        req_valid = 1'b1;
        req_rs = rs; req_rt = rt; req_we = we; req_rd = rd; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        wr = we && (rd != 5'd0);
        check_val("issue_en", rf_en, 1'b1);
        check_val("issue_we", rf_reg_write, wr);
        check_val("issue_rs", rf_read_reg1, rs);
        check_val("issue_rt", rf_read_reg2, rt);
        check_val("issue_busy", busy, 1'b1);
        check_val("issue_ready", req_ready, 1'b0);
        if (wr) begin
            check_val("issue_rd", rf_write_reg, rd);
            check_val("issue_wd", rf_write_data, wd);
        end
        // expected response from architectural register contents
        to = (dly >= TO);
        e1 = ref_regs[rs];
        e2 = ref_regs[rt];
`ifdef RF_BYPASS_EN
        if (wr && rd == rs) e1 = wd;
        if (wr && rd == rt) e2 = wd;
`endif
        if (to) begin
            e1 = '0;
            e2 = '0;
        end
        if (wr) ref_regs[rd] = wd;
        exp_lat = to ? (2 + TO - 1) : (2 + dly);
        n = 0;
        do begin
            tick();
            n++;
            check_val("en_single", rf_en, 1'b0);
        end while (!rsp_valid && n < 40);
        check_val("latency", n, exp_lat);
        check_val("rsp_valid", rsp_valid, 1'b1);
        check_val("rsp_err", rsp_err, to);
        check_val("rsp_data1", rsp_data1, e1);
        check_val("rsp_data2", rsp_data2, e2);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            tick();
            check_val("stall_valid", rsp_valid, 1'b1);
            check_val("stall_data1", rsp_data1, e1);
            check_val("stall_data2", rsp_data2, e2);
            check_val("stall_ready", req_ready, 1'b0);
            check_val("stall_en", rf_en, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("done_valid", rsp_valid, 1'b0);
        check_val("done_err", rsp_err, 1'b0);
        check_val("done_busy", busy, 1'b0);
        check_val("done_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       we;
        int         r;
        n_checks = 0;
        n_errs = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        rst = 1'b1; mem_init = 1'b1; done_delay = 0;
        req_valid = 1'b0; req_rs = '0; req_rt = '0; req_we = 1'b0; req_rd = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_ready", req_ready, 1'b0);
        check_val("rst_en", rf_en, 1'b0);
        check_val("rst_valid", rsp_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rdata1", rsp_data1, 32'h0);
        check_val("rst_wreg", rf_write_reg, 5'd0);
        rst = 1'b0; mem_init = 1'b0;
        #1;
        check_val("post_rst_ready", req_ready, 1'b1);

        // preload and basic read
        do_req(5'd0, 5'd0, 1'b1, 5'd5, 32'h0000_1234, 0, 0);
        do_req(5'd0, 5'd0, 1'b1, 5'd6, 32'hDEAD_BEEF, 0, 0);
        do_req(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 0, 0);
        // write to r0 suppressed
        do_req(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 0, 0);
        do_req(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 0, 0);
        // read-after-write within one request
        do_req(5'd0, 5'd0, 1'b1, 5'd7, 32'h0000_0011, 0, 0);
        do_req(5'd7, 5'd6, 1'b1, 5'd7, 32'hA5A5_A5A5, 0, 0);
        do_req(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 0, 0);
        // back-pressure
        do_req(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1, 10);
        // timeout boundary, then last-chance done, then normal
        do_req(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, TO, 0);
        do_req(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, TO - 1, 2);
        do_req(5'd6, 5'd5, 1'b0, 5'd0, 32'h0, 0, 0);

        // reset in WAIT: write already issued is kept
        done_delay = 100;
        req_valid = 1'b1; req_rs = 5'd3; req_rt = 5'd4; req_we = 1'b1; req_rd = 5'd3; req_wdata = 32'h0BAD_F00D;
        tick();
        req_valid = 1'b0;
        ref_regs[3] = 32'h0BAD_F00D;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_valid", rsp_valid, 1'b0);
        check_val("mid_rst_en", rf_en, 1'b0);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_ready", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_val("mid_rst_ready_after", req_ready, 1'b1);
        do_req(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 0, 0);

        // randomized requests over a small register set to provoke collisions
        for (int k = 0; k < 40; k++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            do_req(rs, rt, we, rd, $urandom, (r < 7) ? (r % 3) : (TO + r - 7), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
